// File: rtl/noc_pkg.sv
// Shared definitions for the NoC egress buffer: beat layout helpers and output FSM states.
package noc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_t;

    function automatic int keep_w(input int bw);
        return bw / 8;
    endfunction

    function automatic int data_w(input int bw);
        return bw + keep_w(bw) + 1;
    endfunction

    // Stored beats are packed {TLAST, TKEEP, TDATA} with TDATA at bit 0.
    function automatic int keep_lsb(input int bw);
        return bw;
    endfunction

    function automatic int last_pos(input int bw);
        return bw + keep_w(bw);
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with the head word combinationally visible on dout.
// Writes while full and reads while empty are ignored.
module noc_sync_fifo #(
    parameter int DATA_W = 37,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              wr_fire;
    logic              rd_fire;

    assign full    = (count_reg == DEPTH_CNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;
    assign dout    = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/noc_buffer_out.sv
// Egress store-and-forward buffer: releases a packet to the NoC only after its TLAST
// beat is stored, falling back to cut-through when a packet fills the whole FIFO.
module noc_buffer_out
    import noc_pkg::*;
#(
    parameter int BW     = 32,
    parameter int BWB    = BW / 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clk_rst_high,
    input  logic              stream_in_TVALID,
    input  logic [BW-1:0]     stream_in_TDATA,
    input  logic [BWB-1:0]    stream_in_TKEEP,
    input  logic              stream_in_TLAST,
    output logic              stream_in_TREADY,
    output logic              stream_out_TVALID,
    output logic [BW-1:0]     stream_out_TDATA,
    output logic [BWB-1:0]    stream_out_TKEEP,
    output logic              stream_out_TLAST,
    input  logic              stream_out_TREADY,
    output logic [ADDR_W:0]   pkt_count,
    output logic [ADDR_W:0]   fill_level,
    output logic              cut_through
);

    localparam int              DATA_W   = data_w(BW);
    localparam int              KEEP_LSB = keep_lsb(BW);
    localparam int              LAST_POS = last_pos(BW);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] fifo_din;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_count;
    logic              wr_fire;
    logic              pop;

    logic [BW-1:0]     head_data;
    logic [BWB-1:0]    head_keep;
    logic              head_last;

    out_state_t        state_reg;
    logic              out_valid_reg;
    logic [BW-1:0]     out_data_reg;
    logic [BWB-1:0]    out_keep_reg;
    logic              out_last_reg;
    logic              cut_through_reg;
    logic [ADDR_W:0]   pkt_count_reg;

    logic              out_hs;
    logic              in_last_fire;
    logic              out_last_fire;

    // Ready depends on registered occupancy only, never on the tile's TVALID.
    assign stream_in_TREADY = ~fifo_full & ~clk_rst_high;
    assign wr_fire          = stream_in_TVALID & stream_in_TREADY;
    assign fifo_din         = {stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA};

    assign head_data = fifo_dout[BW-1:0];
    assign head_keep = fifo_dout[LAST_POS-1:KEEP_LSB];
    assign head_last = fifo_dout[LAST_POS];

    assign out_hs        = out_valid_reg & stream_out_TREADY;
    assign in_last_fire  = wr_fire & stream_in_TLAST;
    assign out_last_fire = out_hs & out_last_reg;

    noc_sync_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .srst  (clk_rst_high),
        .wr_en (wr_fire),
        .din   (fifo_din),
        .full  (fifo_full),
        .rd_en (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // out_last_reg doubles as "last popped beat was TLAST": data is held after a
    // handshake, so it always reflects the most recent pop while in SEND.
    always_comb begin
        pop = 1'b0;
        case (state_reg)
            IDLE:    pop = ~fifo_empty & ((pkt_count_reg != '0) | fifo_full);
            SEND:    pop = ~fifo_empty & ~out_last_reg & (~out_valid_reg | out_hs);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clk_rst_high) begin
            state_reg       <= IDLE;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_keep_reg    <= '0;
            out_last_reg    <= 1'b0;
            cut_through_reg <= 1'b0;
            pkt_count_reg   <= '0;
        end else begin
            case ({in_last_fire, out_last_fire})
                2'b10:   pkt_count_reg <= pkt_count_reg + CNT_ONE;
                2'b01:   pkt_count_reg <= pkt_count_reg - CNT_ONE;
                default: pkt_count_reg <= pkt_count_reg;
            endcase

            // Output stage only changes on a pop, so a stalled beat stays put.
            if (pop) begin
                out_data_reg  <= head_data;
                out_keep_reg  <= head_keep;
                out_last_reg  <= head_last;
                out_valid_reg <= 1'b1;
            end else if (out_hs) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg       <= SEND;
                        cut_through_reg <= (pkt_count_reg == '0);
                    end
                end
                SEND: begin
                    if (out_last_fire) begin
                        state_reg       <= IDLE;
                        cut_through_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stream_out_TVALID = out_valid_reg;
    assign stream_out_TDATA  = out_data_reg;
    assign stream_out_TKEEP  = out_keep_reg;
    assign stream_out_TLAST  = out_last_reg;
    assign pkt_count         = pkt_count_reg;
    assign fill_level        = fifo_count;
    assign cut_through       = cut_through_reg;

endmodule

// File: tb/tb_noc_buffer_out.sv
// Scenario bench for noc_buffer_out: accepted input beats feed an expected queue,
// observed output handshakes feed a second queue, and each scenario compares them.
module tb_noc_buffer_out;

    localparam int BW     = 32;
    localparam int BWB    = 4;
    localparam int ADDR_W = 3;
    localparam int DW     = BW + BWB + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [BW-1:0]     in_data;
    logic [BWB-1:0]    in_keep;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic [BW-1:0]     out_data;
    logic [BWB-1:0]    out_keep;
    logic              out_last;
    logic              out_ready;
    logic [ADDR_W:0]   pkt_count;
    logic [ADDR_W:0]   fill_level;
    logic              cut_through;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    int            obs_cyc[$];
    bit            src_en;
    bit            in_hs_seen;
    bit            in_hs_last;
    int            in_hs_cyc;

    always #5 clk = ~clk;

    noc_buffer_out #(
        .BW     (BW),
        .BWB    (BWB),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk               (clk),
        .clk_rst_high      (rst),
        .stream_in_TVALID  (in_valid),
        .stream_in_TDATA   (in_data),
        .stream_in_TKEEP   (in_keep),
        .stream_in_TLAST   (in_last),
        .stream_in_TREADY  (in_ready),
        .stream_out_TVALID (out_valid),
        .stream_out_TDATA  (out_data),
        .stream_out_TKEEP  (out_keep),
        .stream_out_TLAST  (out_last),
        .stream_out_TREADY (out_ready),
        .pkt_count         (pkt_count),
        .fill_level        (fill_level),
        .cut_through       (cut_through)
    );

    function automatic logic [DW-1:0] mk(input logic last, input logic [BWB-1:0] keep, input logic [BW-1:0] data);
        return {last, keep, data};
    endfunction

    task automatic drive_src();
        if (src_en && src_q.size() > 0) begin
            in_valid = 1'b1;
            {in_last, in_keep, in_data} = src_q[0];
        end else begin
            in_valid = 1'b0;
            {in_last, in_keep, in_data} = '0;
        end
    endtask

    // One clock: record handshakes at the falling edge, update stimulus after the rising edge.
    task automatic tick();
        in_hs_seen = 1'b0;
        in_hs_last = 1'b0;
        @(negedge clk);
        if (in_valid && in_ready) begin
            in_hs_seen = 1'b1;
            in_hs_last = in_last;
            in_hs_cyc  = cyc;
            exp_q.push_back(src_q.pop_front());
        end
        if (out_valid && out_ready) begin
            obs_q.push_back({out_last, out_keep, out_data});
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_src();
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({out_valid, out_last, out_keep, out_data} !== '0 || cut_through !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: got v=%b l=%b k=%h d=%h ct=%b, want all 0", out_valid, out_last, out_keep, out_data, cut_through);
        end
        vectors++;
        if (pkt_count !== '0 || fill_level !== '0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cnt: got pkt=%0d fill=%0d rdy=%b, want 0 0 0", pkt_count, fill_level, in_ready);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_tready: got %b want 1", in_ready);
        end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_single_packet();
        int tlast_cyc;
        tlast_cyc = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) src_q.push_back(mk(i == 3, 4'hF, 32'(8'h11 * (i + 1))));
        drive_src();
        for (int n = 0; n < 16; n++) begin
            tick();
            if (in_hs_seen && in_hs_last) begin
                tlast_cyc = in_hs_cyc;
                vectors++;
                if (pkt_count !== 4'd1) begin
                    miscompares++;
                    $display("FAIL single_pkt_count_up: got %0d want 1", pkt_count);
                end
            end
        end
        vectors++;
        if (obs_q.size() != 4) begin
            miscompares++;
            $display("FAIL single_count: got %0d beats want 4", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            vectors++;
            if (obs_cyc[0] !== tlast_cyc + 2) begin
                miscompares++;
                $display("FAIL single_latency: first beat cycle %0d want %0d", obs_cyc[0], tlast_cyc + 2);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== obs_cyc[0] + i) begin
                miscompares++;
                $display("FAIL single_beat%0d: got %h @%0d want %h @%0d", i, obs_q[i], obs_cyc[i], exp_q[i], obs_cyc[0] + i);
            end
            $display("single: beat %0d out %h at cycle %0d", i, obs_q[i], obs_cyc[i]);
        end
        vectors++;
        if (pkt_count !== '0) begin
            miscompares++;
            $display("FAIL single_pkt_count_down: got %0d want 0", pkt_count);
        end
        clear_queues();
    endtask

    task automatic test_backpressure();
        bit            pat[6];
        logic [DW-1:0] prev;
        logic          prev_v;
        int            n;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        out_ready = 1'b0;
        src_q.push_back(mk(1'b0, 4'hF, 32'hA1));
        src_q.push_back(mk(1'b0, 4'hF, 32'hA2));
        src_q.push_back(mk(1'b1, 4'h7, 32'hA3));
        drive_src();
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_timeout: TVALID got %b want 1", out_valid);
        end
        for (int k = 0; k < 6; k++) begin
            prev   = {out_last, out_keep, out_data};
            prev_v = out_valid;
            out_ready = pat[k];
            tick();
            if (!pat[k] && prev_v) begin
                vectors++;
                if (out_valid !== 1'b1 || {out_last, out_keep, out_data} !== prev) begin
                    miscompares++;
                    $display("FAIL bp_hold%0d: got v=%b %h want v=1 %h", k, out_valid, {out_last, out_keep, out_data}, prev);
                end
            end
        end
        out_ready = 1'b1;
        repeat (3) tick();
        vectors++;
        if (obs_q.size() != 3) begin
            miscompares++;
            $display("FAIL bp_count: got %0d beats want 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
            $display("backpressure: beat %0d out %h at cycle %0d", i, obs_q[i], obs_cyc[i]);
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        int         peak;
        int         gap[6];
        logic [7:0] base[3];
        gap  = '{0, 1, 3, 4, 6, 7};
        base = '{8'hB0, 8'hC0, 8'hD0};
        peak = 0;
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            src_q.push_back(mk(1'b0, 4'hF, 32'(base[p] + 8'h1)));
            src_q.push_back(mk(1'b1, 4'hF, 32'(base[p] + 8'h2)));
        end
        drive_src();
        for (int n = 0; n < 12; n++) begin
            tick();
            if (int'(pkt_count) > peak) peak = int'(pkt_count);
        end
        vectors++;
        if (peak !== 3) begin
            miscompares++;
            $display("FAIL b2b_peak: got %0d want 3", peak);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 14; n++) tick();
        vectors++;
        if (obs_q.size() != 6) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d beats want 6", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size() && i < 6; i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i] || obs_cyc[i] - obs_cyc[0] !== gap[i]) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: got %h offset %0d want %h offset %0d", i, obs_q[i], obs_cyc[i] - obs_cyc[0], exp_q[i], gap[i]);
            end
            $display("back_to_back: beat %0d out %h at cycle %0d", i, obs_q[i], obs_cyc[i]);
        end
        vectors++;
        if (pkt_count !== '0) begin
            miscompares++;
            $display("FAIL b2b_pkt_end: got %0d want 0", pkt_count);
        end
        clear_queues();
    endtask

    task automatic test_full_cut_through();
        int acc;
        int n;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) src_q.push_back(mk(i == 9, 4'hF, 32'h100 + 32'(i)));
        drive_src();
        acc = 0;
        n   = 0;
        while (acc < 8 && n < 20) begin
            tick();
            if (in_hs_seen) acc++;
            n++;
        end
        vectors++;
        if (acc != 8 || in_ready !== 1'b0 || fill_level !== 4'd8) begin
            miscompares++;
            $display("FAIL full_state: got writes=%0d rdy=%b fill=%0d want 8 0 8", acc, in_ready, fill_level);
        end
        tick();
        vectors++;
        if (in_hs_seen || cut_through !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h100) begin
            miscompares++;
            $display("FAIL ct_start: got wr=%b ct=%b v=%b d=%h want 0 1 1 00000100", in_hs_seen, cut_through, out_valid, out_data);
        end
        vectors++;
        if (in_ready !== 1'b1 || fill_level !== 4'd7) begin
            miscompares++;
            $display("FAIL ct_tready_back: got rdy=%b fill=%0d want 1 7", in_ready, fill_level);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (cut_through !== 1'b1) begin
            miscompares++;
            $display("FAIL ct_mid: got cut_through=%b want 1", cut_through);
        end
        for (int k = 0; k < 20; k++) tick();
        vectors++;
        if (cut_through !== 1'b0 || pkt_count !== '0 || fill_level !== '0) begin
            miscompares++;
            $display("FAIL ct_end: got ct=%b pkt=%0d fill=%0d want 0 0 0", cut_through, pkt_count, fill_level);
        end
        vectors++;
        if (obs_q.size() != 10) begin
            miscompares++;
            $display("FAIL ct_count: got %0d beats want 10", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL ct_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
            $display("cut_through: beat %0d out %h at cycle %0d", i, obs_q[i], obs_cyc[i]);
        end
        clear_queues();
    endtask

    task automatic test_simul_push_pop();
        int n;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) src_q.push_back(mk(1'b1, 4'hF, 32'h200 + 32'(i)));
        drive_src();
        n = 0;
        while (!(src_q.size() == 0 && fill_level == 4'd4 && out_valid) && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (pkt_count !== 4'd5 || fill_level !== 4'd4) begin
            miscompares++;
            $display("FAIL pp_setup: got pkt=%0d fill=%0d want 5 4", pkt_count, fill_level);
        end
        src_q.push_back(mk(1'b1, 4'h1, 32'h2A1));
        src_q.push_back(mk(1'b1, 4'h3, 32'h2A2));
        drive_src();
        out_ready = 1'b1;
        tick();
        vectors++;
        if (!in_hs_seen || pkt_count !== 4'd5 || fill_level !== 4'd5) begin
            miscompares++;
            $display("FAIL pp_tlast_both: got wr=%b pkt=%0d fill=%0d want 1 5 5", in_hs_seen, pkt_count, fill_level);
        end
        tick();
        vectors++;
        if (!in_hs_seen || fill_level !== 4'd5 || pkt_count !== 4'd6) begin
            miscompares++;
            $display("FAIL pp_fill_hold: got wr=%b fill=%0d pkt=%0d want 1 5 6", in_hs_seen, fill_level, pkt_count);
        end
        for (int k = 0; k < 30; k++) tick();
        vectors++;
        if (obs_q.size() != 7 || pkt_count !== '0) begin
            miscompares++;
            $display("FAIL pp_drain: got %0d beats pkt=%0d want 7 0", obs_q.size(), pkt_count);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL pp_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
            $display("push_pop: beat %0d out %h at cycle %0d", i, obs_q[i], obs_cyc[i]);
        end
        clear_queues();
    endtask

    task automatic test_reset_mid();
        int            n;
        logic [DW-1:0] want;
        want = mk(1'b1, 4'hF, 32'hAB);
        out_ready = 1'b0;
        src_q.push_back(mk(1'b1, 4'hF, 32'hF0));
        src_q.push_back(mk(1'b0, 4'hF, 32'hF1));
        src_q.push_back(mk(1'b0, 4'hF, 32'hF2));
        drive_src();
        n = 0;
        while (!(src_q.size() == 0 && out_valid) && n < 20) begin
            tick();
            n++;
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || fill_level !== 4'd2) begin
            miscompares++;
            $display("FAIL rm_setup: got v=%b fill=%0d want 1 2", out_valid, fill_level);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({out_valid, out_last, out_keep, out_data} !== '0 || pkt_count !== '0 || fill_level !== '0 || cut_through !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_cleared: got v=%b d=%h pkt=%0d fill=%0d ct=%b rdy=%b want all 0", out_valid, out_data, pkt_count, fill_level, cut_through, in_ready);
        end
        src_q.delete();
        clear_queues();
        rst = 1'b0;
        drive_src();
        tick();
        src_q.push_back(want);
        drive_src();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL rm_count: got %0d beats want 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            vectors++;
            if (obs_q[0] !== want) begin
                miscompares++;
                $display("FAIL rm_beat: got %h want %h", obs_q[0], want);
            end
            $display("reset_mid: beat 0 out %h at cycle %0d", obs_q[0], obs_cyc[0]);
        end
        vectors++;
        if (pkt_count !== '0 || fill_level !== '0) begin
            miscompares++;
            $display("FAIL rm_end: got pkt=%0d fill=%0d want 0 0", pkt_count, fill_level);
        end
        clear_queues();
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        src_en    = 1'b1;
        drive_src();
        test_reset();
        test_single_packet();
        test_backpressure();
        test_back_to_back();
        test_full_cut_through();
        test_simul_push_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
